// File: rtl/mat_rd_port_arbiter_if.sv
// Request-side and storage-side signals of the matrix read-port arbiter.
// slave is the arbiter's view; master is the view of the units and storage around it.
interface mat_rd_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DIM_WIDTH  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]           req_rd_en;
    logic [NUM_REQ-1:0]           req_slot_idx;
    logic [NUM_REQ*DIM_WIDTH-1:0] req_row_idx;
    logic [NUM_REQ*DIM_WIDTH-1:0] req_col_idx;
    logic [DATA_WIDTH-1:0]        req_elem;
    logic [NUM_REQ-1:0]           req_elem_valid;
    logic [NUM_REQ-1:0]           req_timeout;
    logic [NUM_REQ-1:0]           req_overrun;
    logic [NUM_REQ-1:0]           req_pending;
    logic                         mem_rd_en;
    logic                         mem_slot_idx;
    logic [DIM_WIDTH-1:0]         mem_row_idx;
    logic [DIM_WIDTH-1:0]         mem_col_idx;
    logic [DATA_WIDTH-1:0]        mem_rd_elem;
    logic                         mem_rd_elem_valid;
    logic [IDX_W-1:0]             grant_idx;
    logic                         busy;

    modport slave (
        input  req_rd_en, req_slot_idx, req_row_idx, req_col_idx,
               mem_rd_elem, mem_rd_elem_valid,
        output req_elem, req_elem_valid, req_timeout, req_overrun, req_pending,
               mem_rd_en, mem_slot_idx, mem_row_idx, mem_col_idx, grant_idx, busy
    );

    modport master (
        output req_rd_en, req_slot_idx, req_row_idx, req_col_idx,
               mem_rd_elem, mem_rd_elem_valid,
        input  req_elem, req_elem_valid, req_timeout, req_overrun, req_pending,
               mem_rd_en, mem_slot_idx, mem_row_idx, mem_col_idx, grant_idx, busy
    );
endinterface

// File: rtl/mat_rd_port_arbiter.sv
// Round-robin arbiter sharing one matrix-storage read port among NUM_REQ units,
// with per-requester pending slots and a watchdog that retires unanswered reads.
module mat_rd_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIM_WIDTH      = 3,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    mat_rd_port_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

    state_e                              state_q, state_d;
    logic [NUM_REQ-1:0]                  pend_q, pend_d;
    logic [NUM_REQ-1:0]                  slot_q, slot_d;
    logic [NUM_REQ-1:0][DIM_WIDTH-1:0]   row_q, row_d;
    logic [NUM_REQ-1:0][DIM_WIDTH-1:0]   col_q, col_d;
    logic [IDX_W-1:0]                    grant_q, grant_d;
    logic [IDX_W-1:0]                    last_q, last_d;
    logic [TMR_W-1:0]                    timer_q, timer_d;
    logic [DATA_WIDTH-1:0]               elem_q, elem_d;
    logic [NUM_REQ-1:0]                  evld_q, evld_d;
    logic [NUM_REQ-1:0]                  tout_q, tout_d;
    logic [NUM_REQ-1:0]                  ovr_q, ovr_d;
    logic                                mrd_q, mrd_d;
    logic                                mslot_q, mslot_d;
    logic [DIM_WIDTH-1:0]                mrow_q, mrow_d;
    logic [DIM_WIDTH-1:0]                mcol_q, mcol_d;
    logic [NUM_REQ-1:0]                  clr;
    logic [IDX_W-1:0]                    win;
    logic                                found;

    // Rotating priority: first pending requester after the last one retired.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && pend_q[(int'(last_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        row_d   = row_q;
        col_d   = col_q;
        grant_d = grant_q;
        last_d  = last_q;
        timer_d = timer_q;
        elem_d  = elem_q;
        mrd_d   = 1'b0;
        mslot_d = mslot_q;
        mrow_d  = mrow_q;
        mcol_d  = mcol_q;
        evld_d  = '0;
        tout_d  = '0;
        ovr_d   = '0;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = win;
                    mrd_d   = 1'b1;
                    mslot_d = slot_q[win];
                    mrow_d  = row_q[win];
                    mcol_d  = col_q[win];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_elem_valid) begin
                    elem_d          = bus.mem_rd_elem;
                    evld_d[grant_q] = 1'b1;
                    clr[grant_q]    = 1'b1;
                    last_d          = grant_q;
                    state_d         = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    tout_d[grant_q] = 1'b1;
                    clr[grant_q]    = 1'b1;
                    last_d          = grant_q;
                    state_d         = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A slot retired this cycle is free again, so a new pulse on it is accepted.
        pend_d = pend_q & ~clr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_rd_en[i]) begin
                if (pend_d[i]) begin
                    ovr_d[i] = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    slot_d[i] = bus.req_slot_idx[i];
                    row_d[i]  = bus.req_row_idx[i*DIM_WIDTH +: DIM_WIDTH];
                    col_d[i]  = bus.req_col_idx[i*DIM_WIDTH +: DIM_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            slot_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            timer_q <= '0;
            elem_q  <= '0;
            evld_q  <= '0;
            tout_q  <= '0;
            ovr_q   <= '0;
            mrd_q   <= 1'b0;
            mslot_q <= 1'b0;
            mrow_q  <= '0;
            mcol_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            slot_q  <= slot_d;
            row_q   <= row_d;
            col_q   <= col_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            timer_q <= timer_d;
            elem_q  <= elem_d;
            evld_q  <= evld_d;
            tout_q  <= tout_d;
            ovr_q   <= ovr_d;
            mrd_q   <= mrd_d;
            mslot_q <= mslot_d;
            mrow_q  <= mrow_d;
            mcol_q  <= mcol_d;
        end
    end

    assign bus.req_elem       = elem_q;
    assign bus.req_elem_valid = evld_q;
    assign bus.req_timeout    = tout_q;
    assign bus.req_overrun    = ovr_q;
    assign bus.req_pending    = pend_q;
    assign bus.mem_rd_en      = mrd_q;
    assign bus.mem_slot_idx   = mslot_q;
    assign bus.mem_row_idx    = mrow_q;
    assign bus.mem_col_idx    = mcol_q;
    assign bus.grant_idx      = grant_q;
    assign bus.busy           = (state_q != IDLE) || (|pend_q);
endmodule

// File: tb/tb_mat_rd_port_arbiter.sv
// Bench for mat_rd_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_mat_rd_port_arbiter;
    localparam int N  = 4;
    localparam int DW = 3;
    localparam int EW = 8;
    localparam int TO = 16;

    logic clk, rst;
    int   n_chk, n_fail;

    mat_rd_port_arbiter_if #(.NUM_REQ(N), .DIM_WIDTH(DW), .DATA_WIDTH(EW)) bus();

    mat_rd_port_arbiter #(.NUM_REQ(N), .DIM_WIDTH(DW), .DATA_WIDTH(EW), .TIMEOUT_CYCLES(TO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.req_rd_en         = '0;
        bus.req_slot_idx      = '0;
        bus.req_row_idx       = '0;
        bus.req_col_idx       = '0;
        bus.mem_rd_elem_valid = 1'b0;
    endtask

    task automatic set_req(input int i, input logic s, input logic [DW-1:0] r, input logic [DW-1:0] c);
        bus.req_rd_en[i]              = 1'b1;
        bus.req_slot_idx[i]           = s;
        bus.req_row_idx[i*DW +: DW]   = r;
        bus.req_col_idx[i*DW +: DW]   = c;
    endtask

    task automatic reply(input logic [EW-1:0] d);
        bus.mem_rd_elem       = d;
        bus.mem_rd_elem_valid = 1'b1;
        tick();
        bus.mem_rd_elem_valid = 1'b0;
    endtask

    task automatic do_reset();
        clr_inputs();
        bus.mem_rd_elem = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_mrd(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (bus.mem_rd_en) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        clr_inputs();
        bus.mem_rd_elem = '0;
        rst = 1'b1;
        bus.req_rd_en = '1;
        tick();
        tick();
        n_chk++; if (bus.req_pending !== 4'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", bus.req_pending); end
        n_chk++; if ({bus.req_elem_valid, bus.req_timeout, bus.req_overrun} !== 12'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0", {bus.req_elem_valid, bus.req_timeout, bus.req_overrun}); end
        n_chk++; if (bus.req_elem !== 8'h00) begin n_fail++; $display("FAIL reset_elem: got %h want 00", bus.req_elem); end
        n_chk++; if ({bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx} !== 8'b0) begin n_fail++; $display("FAIL reset_mem: got %b want 0", {bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx}); end
        n_chk++; if ({bus.grant_idx, bus.busy} !== 3'b0) begin n_fail++; $display("FAIL reset_grant_busy: got %b want 000", {bus.grant_idx, bus.busy}); end
        clr_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(1, 1'b1, 3'd2, 3'd1);
        tick(); clr_inputs();                                   // cycle 1
        n_chk++; if (bus.req_pending !== 4'b0010) begin n_fail++; $display("FAIL t1_pending: got %b want 0010", bus.req_pending); end
        n_chk++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL t1_early_rd: got %b want 0", bus.mem_rd_en); end
        tick();                                                 // cycle 2
        n_chk++; if ({bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx} !== {1'b1, 1'b1, 3'd2, 3'd1}) begin n_fail++; $display("FAIL t1_issue: got %b want 1_1_010_001", {bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx}); end
        n_chk++; if (bus.grant_idx !== 2'd1) begin n_fail++; $display("FAIL t1_grant: got %0d want 1", bus.grant_idx); end
        tick();                                                 // cycle 3
        n_chk++; if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL t1_rd_one_cycle: got %b want 0", bus.mem_rd_en); end
        reply(8'h5A);                                           // cycle 4
        n_chk++; if (bus.req_elem_valid !== 4'b0010) begin n_fail++; $display("FAIL t1_valid: got %b want 0010", bus.req_elem_valid); end
        n_chk++; if (bus.req_elem !== 8'h5A) begin n_fail++; $display("FAIL t1_elem: got %h want 5a", bus.req_elem); end
        tick();                                                 // cycle 5
        n_chk++; if ({bus.req_elem_valid, bus.busy} !== 5'b0) begin n_fail++; $display("FAIL t1_after: got %b want 00000", {bus.req_elem_valid, bus.busy}); end
        n_chk++; if ({bus.req_elem, bus.mem_slot_idx, bus.mem_row_idx} !== {8'h5A, 1'b1, 3'd2}) begin n_fail++; $display("FAIL t1_hold: got %h want 5a/1/2", {bus.req_elem, bus.mem_slot_idx, bus.mem_row_idx}); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int ord2[2] = '{1, 3};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'(i & 1), DW'(i), DW'(i + 1));
        tick(); clr_inputs();
        n_chk++; if (bus.req_pending !== 4'b1111) begin n_fail++; $display("FAIL rr_pending: got %b want 1111", bus.req_pending); end
        for (int j = 0; j < N + 2; j++) begin
            int exp_g;
            if (j == N) begin
                set_req(3, 1'b1, 3'd3, 3'd4);
                set_req(1, 1'b1, 3'd1, 3'd2);
                tick(); clr_inputs();
            end
            exp_g = (j < N) ? j : ord2[j - N];
            wait_mrd(8, ok);
            n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_issue_wait: got no mem_rd_en want issue for req %0d", exp_g); end
            n_chk++; if ({bus.grant_idx, bus.mem_row_idx} !== {2'(exp_g), 3'(exp_g)}) begin n_fail++; $display("FAIL rr_grant: got grant %0d row %0d want %0d", bus.grant_idx, bus.mem_row_idx, exp_g); end
            tick();
            reply(8'h10 + 8'(j));
            n_chk++; if (bus.req_elem_valid !== (4'b1 << exp_g)) begin n_fail++; $display("FAIL rr_valid: got %b want %b", bus.req_elem_valid, 4'b1 << exp_g); end
            n_chk++; if (bus.req_overrun !== 4'b0) begin n_fail++; $display("FAIL rr_overrun: got %b want 0000", bus.req_overrun); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(2, 1'b0, 3'd3, 3'd3);
        tick(); clr_inputs();
        set_req(0, 1'b1, 3'd4, 3'd4);
        tick(); clr_inputs();                                   // cycle 2
        n_chk++; if ({bus.mem_rd_en, bus.grant_idx} !== 3'b110) begin n_fail++; $display("FAIL to_issue: got %b want 1_10", {bus.mem_rd_en, bus.grant_idx}); end
        tick();                                                 // cycle 3: WAIT entry
        for (int k = 0; k < TO; k++) begin
            n_chk++; if ({bus.req_timeout, bus.req_elem_valid} !== 8'b0) begin n_fail++; $display("FAIL to_early: wait cycle %0d got %b want 0", k, {bus.req_timeout, bus.req_elem_valid}); end
            tick();
        end                                                     // cycle 19
        n_chk++; if (bus.req_timeout !== 4'b0100) begin n_fail++; $display("FAIL to_pulse: got %b want 0100", bus.req_timeout); end
        n_chk++; if ({bus.req_elem_valid, bus.req_pending} !== 8'b0000_0001) begin n_fail++; $display("FAIL to_state: got %b want 0000_0001", {bus.req_elem_valid, bus.req_pending}); end
        tick();                                                 // cycle 20
        n_chk++; if ({bus.mem_rd_en, bus.grant_idx, bus.mem_row_idx} !== {1'b1, 2'd0, 3'd4}) begin n_fail++; $display("FAIL to_next_issue: got %b want 1_00_100", {bus.mem_rd_en, bus.grant_idx, bus.mem_row_idx}); end
        tick();
        reply(8'h33);
        n_chk++; if ({bus.req_elem_valid, bus.req_elem} !== {4'b0001, 8'h33}) begin n_fail++; $display("FAIL to_next_valid: got %h want 133", {bus.req_elem_valid, bus.req_elem}); end
    endtask

    task automatic test_overrun();
        do_reset();
        set_req(0, 1'b0, 3'd1, 3'd1);
        tick(); clr_inputs();                                   // cycle 1
        set_req(0, 1'b1, 3'd5, 3'd5);
        tick(); clr_inputs();                                   // cycle 2
        n_chk++; if (bus.req_overrun !== 4'b0001) begin n_fail++; $display("FAIL ov_pulse: got %b want 0001", bus.req_overrun); end
        n_chk++; if ({bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx} !== {1'b1, 1'b0, 3'd1}) begin n_fail++; $display("FAIL ov_first_addr: got %b want 1_0_001", {bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx}); end
        tick();                                                 // cycle 3
        n_chk++; if (bus.req_overrun !== 4'b0) begin n_fail++; $display("FAIL ov_once: got %b want 0000", bus.req_overrun); end
        reply(8'h44);                                           // cycle 4
        n_chk++; if ({bus.req_elem_valid, bus.req_pending} !== 8'b0001_0000) begin n_fail++; $display("FAIL ov_served: got %b want 0001_0000", {bus.req_elem_valid, bus.req_pending}); end
        set_req(0, 1'b1, 3'd6, 3'd2);
        tick(); clr_inputs();                                   // cycle 5
        n_chk++; if ({bus.req_overrun, bus.req_pending} !== 8'b0000_0001) begin n_fail++; $display("FAIL ov_repulse: got %b want 0000_0001", {bus.req_overrun, bus.req_pending}); end
        tick();                                                 // cycle 6
        n_chk++; if ({bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx} !== {1'b1, 1'b1, 3'd6, 3'd2}) begin n_fail++; $display("FAIL ov_repulse_addr: got %b want 1_1_110_010", {bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx}); end
        tick();                                                 // cycle 7: retire and re-request together
        set_req(0, 1'b0, 3'd7, 3'd7);
        reply(8'h55);                                           // cycle 8
        clr_inputs();
        n_chk++; if ({bus.req_elem_valid, bus.req_overrun, bus.req_pending} !== 12'b0001_0000_0001) begin n_fail++; $display("FAIL ov_set_wins: got %b want 0001_0000_0001", {bus.req_elem_valid, bus.req_overrun, bus.req_pending}); end
        n_chk++; if (bus.req_elem !== 8'h55) begin n_fail++; $display("FAIL ov_elem: got %h want 55", bus.req_elem); end
        tick();                                                 // cycle 9
        n_chk++; if ({bus.mem_rd_en, bus.mem_row_idx} !== {1'b1, 3'd7}) begin n_fail++; $display("FAIL ov_third_issue: got %b want 1_111", {bus.mem_rd_en, bus.mem_row_idx}); end
        tick();
        reply(8'h66);
        n_chk++; if ({bus.req_elem_valid, bus.req_elem} !== {4'b0001, 8'h66}) begin n_fail++; $display("FAIL ov_third_valid: got %h want 166", {bus.req_elem_valid, bus.req_elem}); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        set_req(3, 1'b1, 3'd7, 3'd7);
        tick(); clr_inputs();
        tick();                                                 // ISSUE
        tick();                                                 // WAIT
        rst = 1'b1;
        tick();
        n_chk++; if ({bus.req_pending, bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.grant_idx, bus.busy} !== 13'b0) begin n_fail++; $display("FAIL rw_reset: got %b want 0", {bus.req_pending, bus.mem_rd_en, bus.mem_slot_idx, bus.mem_row_idx, bus.grant_idx, bus.busy}); end
        rst = 1'b0;
        reply(8'hAA);
        n_chk++; if ({bus.req_elem_valid, bus.req_elem, bus.busy} !== 13'b0) begin n_fail++; $display("FAIL rw_late_valid: got %b want 0", {bus.req_elem_valid, bus.req_elem, bus.busy}); end
        tick();
        n_chk++; if ({bus.req_elem_valid, bus.mem_rd_en, bus.req_timeout} !== 9'b0) begin n_fail++; $display("FAIL rw_idle: got %b want 0", {bus.req_elem_valid, bus.mem_rd_en, bus.req_timeout}); end
    endtask

    task automatic test_stray_valid();
        do_reset();
        bus.mem_rd_elem       = 8'hFF;
        bus.mem_rd_elem_valid = 1'b1;
        tick();
        n_chk++; if ({bus.req_elem_valid, bus.req_elem} !== 12'b0) begin n_fail++; $display("FAIL sv_first: got %h want 000", {bus.req_elem_valid, bus.req_elem}); end
        tick();
        bus.mem_rd_elem_valid = 1'b0;
        n_chk++; if ({bus.req_elem_valid, bus.req_elem, bus.busy} !== 13'b0) begin n_fail++; $display("FAIL sv_second: got %h want 0", {bus.req_elem_valid, bus.req_elem, bus.busy}); end
        tick();
        n_chk++; if ({bus.req_elem_valid, bus.req_elem, bus.mem_rd_en} !== 13'b0) begin n_fail++; $display("FAIL sv_third: got %h want 0", {bus.req_elem_valid, bus.req_elem, bus.mem_rd_en}); end
    endtask

    // Model: pending set + saved addresses; a read is issued the cycle after the port
    // is found free with work waiting, and retires on a reply or after TO wait cycles.
    task automatic test_random(input int cycles);
        bit              pend[N];
        logic            ms[N];
        logic [DW-1:0]   mr[N], mc[N];
        int              last, phase, g, wcnt, reply_at;
        logic [EW-1:0]   elem_m, d;
        logic [N-1:0]    e_evld, e_tout, e_ovr, n_evld, n_tout, n_ovr, pvec;
        bit              e_mrd, n_mrd, comp;
        logic            e_s;
        logic [DW-1:0]   e_r, e_c;
        do_reset();
        for (int i = 0; i < N; i++) begin pend[i] = 0; ms[i] = 0; mr[i] = '0; mc[i] = '0; end
        last = N - 1; phase = 0; g = 0; wcnt = 0; reply_at = 0; elem_m = '0;
        e_evld = '0; e_tout = '0; e_ovr = '0; e_mrd = 0; e_s = 0; e_r = '0; e_c = '0;
        for (int n = 0; n < cycles; n++) begin
            for (int i = 0; i < N; i++) pvec[i] = pend[i];
            n_chk++; if (bus.req_elem_valid !== e_evld) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", n, bus.req_elem_valid, e_evld); end
            n_chk++; if (bus.req_timeout !== e_tout) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b want %b", n, bus.req_timeout, e_tout); end
            n_chk++; if (bus.req_overrun !== e_ovr) begin n_fail++; $display("FAIL rnd_overrun c%0d: got %b want %b", n, bus.req_overrun, e_ovr); end
            n_chk++; if (bus.mem_rd_en !== e_mrd) begin n_fail++; $display("FAIL rnd_rd_en c%0d: got %b want %b", n, bus.mem_rd_en, e_mrd); end
            if (e_mrd) begin
                n_chk++; if ({bus.grant_idx, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx} !== {2'(g), e_s, e_r, e_c}) begin n_fail++; $display("FAIL rnd_issue c%0d: got %b want %b", n, {bus.grant_idx, bus.mem_slot_idx, bus.mem_row_idx, bus.mem_col_idx}, {2'(g), e_s, e_r, e_c}); end
            end
            n_chk++; if (bus.req_elem !== elem_m) begin n_fail++; $display("FAIL rnd_elem c%0d: got %h want %h", n, bus.req_elem, elem_m); end
            n_chk++; if (bus.req_pending !== pvec) begin n_fail++; $display("FAIL rnd_pending c%0d: got %b want %b", n, bus.req_pending, pvec); end
            n_chk++; if (bus.busy !== ((phase != 0) || (pvec != '0))) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b want %b", n, bus.busy, (phase != 0) || (pvec != '0)); end

            n_evld = '0; n_tout = '0; n_ovr = '0; n_mrd = 0; comp = 0;
            clr_inputs();
            if (phase == 0) begin
                if (pvec != '0) begin
                    for (int k = 1; k <= N; k++) begin
                        if (pend[(last + k) % N]) begin g = (last + k) % N; break; end
                    end
                    n_mrd = 1; e_s = ms[g]; e_r = mr[g]; e_c = mc[g]; phase = 1;
                end
            end else if (phase == 1) begin
                phase = 2; wcnt = 0;
                reply_at = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(3));
            end else begin
                if (wcnt == reply_at) begin
                    d = EW'($urandom);
                    bus.mem_rd_elem = d; bus.mem_rd_elem_valid = 1'b1;
                    elem_m = d; n_evld[g] = 1'b1; comp = 1;
                end else if (wcnt == TO - 1) begin
                    n_tout[g] = 1'b1; comp = 1;
                end else begin
                    wcnt++;
                end
                if (comp) begin pend[g] = 0; last = g; phase = 0; end
            end
            // Storage data outside a wait is noise the arbiter must ignore.
            if (phase != 2 && !comp && $urandom_range(3) == 0) begin
                bus.mem_rd_elem = EW'($urandom); bus.mem_rd_elem_valid = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(4) == 0) begin
                    logic s; logic [DW-1:0] r, c;
                    s = 1'($urandom); r = DW'($urandom); c = DW'($urandom);
                    set_req(i, s, r, c);
                    if (pend[i]) n_ovr[i] = 1'b1;
                    else begin pend[i] = 1; ms[i] = s; mr[i] = r; mc[i] = c; end
                end
            end
            tick();
            e_evld = n_evld; e_tout = n_tout; e_ovr = n_ovr; e_mrd = n_mrd;
        end
        clr_inputs();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        clr_inputs();
        bus.mem_rd_elem = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_overrun();
        test_reset_mid_wait();
        test_stray_valid();
        test_random(800);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
